// File: rtl/exec_mem_pkg.sv
// Shared opcode/funct constants, ALU operation encoding and the immediate-extension helper.
// Imported by exec_alu and exec_mem_unit.
package exec_mem_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_SLLV    = 6'h04;
    localparam logic [5:0] FN_SRLV    = 6'h06;
    localparam logic [5:0] FN_SRAV    = 6'h07;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2A;
    localparam logic [5:0] FN_SLTU    = 6'h2B;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_NOR  = 5'd5,
        ALU_SLT  = 5'd6,
        ALU_SLTU = 5'd7,
        ALU_SLL  = 5'd8,
        ALU_SRL  = 5'd9,
        ALU_SRA  = 5'd10,
        ALU_SLLV = 5'd11,
        ALU_SRLV = 5'd12,
        ALU_SRAV = 5'd13,
        ALU_LUI  = 5'd14
    } alu_op_e;

    typedef enum logic [1:0] {
        EXT_SIGN = 2'd0,
        EXT_ZERO = 2'd1,
        EXT_LUI  = 2'd2
    } imm_ext_e;

    function automatic logic [31:0] extend_imm(input logic [15:0] imm, input imm_ext_e mode);
        logic [31:0] result;
        case (mode)
            EXT_ZERO: result = {16'h0000, imm};
            EXT_LUI:  result = {imm, 16'h0000};
            default:  result = {{16{imm[15]}}, imm};
        endcase
        return result;
    endfunction

endpackage

// File: rtl/exec_alu.sv
// 32-bit ALU: wrapping arithmetic, logic ops, signed/unsigned compare and shifts.
// Fixed shifts use i_shamt; variable shifts use i_a[4:0]; operand i_b is always the shifted value.
module exec_alu
    import exec_mem_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [4:0]  i_shamt,
    input  alu_op_e     i_ctrl,
    output logic [31:0] o_result
);

    always_comb begin
        o_result = '0;
        case (i_ctrl)
            ALU_ADD:  o_result = i_a + i_b;
            ALU_SUB:  o_result = i_a - i_b;
            ALU_AND:  o_result = i_a & i_b;
            ALU_OR:   o_result = i_a | i_b;
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_NOR:  o_result = ~(i_a | i_b);
            ALU_SLT:  o_result = {31'd0, $signed(i_a) < $signed(i_b)};
            ALU_SLTU: o_result = {31'd0, i_a < i_b};
            ALU_SLL:  o_result = i_b << i_shamt;
            ALU_SRL:  o_result = i_b >> i_shamt;
            ALU_SRA:  o_result = 32'($signed(i_b) >>> i_shamt);
            ALU_SLLV: o_result = i_b << i_a[4:0];
            ALU_SRLV: o_result = i_b >> i_a[4:0];
            ALU_SRAV: o_result = 32'($signed(i_b) >>> i_a[4:0]);
            // The shifted immediate is already formed by the extender.
            ALU_LUI:  o_result = i_b;
            default:  o_result = i_a + i_b;
        endcase
    end

endmodule

// File: rtl/exec_mem_unit.sv
// Execute/memory slice: combinational decode, ALU and a word-addressed data memory.
// Define DMEM_DBG_EN to add the dbgAddr/dbgData side read port.
module exec_mem_unit
    import exec_mem_pkg::*;
#(
    parameter int DMEM_DEPTH = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [31:0] regData1,
    input  logic [31:0] regData2,
    output logic        regWrite,
    output logic [1:0]  regDst,
    output logic [1:0]  memToReg,
    output logic        memRead,
    output logic        memWrite,
    output logic        aluSrc,
    output logic        branch,
    output logic        branchTaken,
    output logic        jump,
    output logic        jumpr,
    output logic        jumpj,
    output logic        syscall,
    output logic [4:0]  aluControl,
    output logic [31:0] aluResult,
    output logic        zero,
    output logic [31:0] memData
`ifdef DMEM_DBG_EN
    ,
    input  logic [$clog2(DMEM_DEPTH)-1:0] dbgAddr,
    output logic [31:0]                   dbgData
`endif
);

    localparam int AW = $clog2(DMEM_DEPTH);

    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;
    logic [4:0]  w_shamt;
    alu_op_e     w_alu_op;
    imm_ext_e    w_ext_mode;
    logic        w_rtype_ok;
    logic        w_itype_ok;
    logic [31:0] w_imm_ext;
    logic [31:0] w_alu_b;
    logic [AW-1:0] w_idx;
    logic [31:0] w_words [DMEM_DEPTH];
    logic        w_unused_fields;

    assign w_opcode = instruction[31:26];
    assign w_funct  = instruction[5:0];
    assign w_imm    = instruction[15:0];
    assign w_shamt  = instruction[10:6];
    // Register specifiers are consumed by the register file, not here.
    assign w_unused_fields = &{1'b0, instruction[25:16]};

    always_comb begin
        regWrite   = 1'b0;
        regDst     = 2'b00;
        memToReg   = 2'b00;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        aluSrc     = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        jumpr      = 1'b0;
        jumpj      = 1'b0;
        syscall    = 1'b0;
        w_alu_op   = ALU_ADD;
        w_ext_mode = EXT_SIGN;
        w_rtype_ok = 1'b0;
        w_itype_ok = 1'b0;
        case (w_opcode)
            OP_RTYPE: begin
                w_rtype_ok = 1'b1;
                case (w_funct)
                    FN_ADD, FN_ADDU: w_alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: w_alu_op = ALU_SUB;
                    FN_AND:          w_alu_op = ALU_AND;
                    FN_OR:           w_alu_op = ALU_OR;
                    FN_XOR:          w_alu_op = ALU_XOR;
                    FN_NOR:          w_alu_op = ALU_NOR;
                    FN_SLT:          w_alu_op = ALU_SLT;
                    FN_SLTU:         w_alu_op = ALU_SLTU;
                    FN_SLL:          w_alu_op = ALU_SLL;
                    FN_SRL:          w_alu_op = ALU_SRL;
                    FN_SRA:          w_alu_op = ALU_SRA;
                    FN_SLLV:         w_alu_op = ALU_SLLV;
                    FN_SRLV:         w_alu_op = ALU_SRLV;
                    FN_SRAV:         w_alu_op = ALU_SRAV;
                    FN_JR: begin
                        w_rtype_ok = 1'b0;
                        jump       = 1'b1;
                        jumpr      = 1'b1;
                    end
                    FN_SYSCALL: begin
                        w_rtype_ok = 1'b0;
                        syscall    = 1'b1;
                    end
                    default:         w_rtype_ok = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                w_itype_ok = 1'b1;
                w_alu_op   = ALU_ADD;
            end
            OP_SLTI: begin
                w_itype_ok = 1'b1;
                w_alu_op   = ALU_SLT;
            end
            OP_SLTIU: begin
                w_itype_ok = 1'b1;
                w_alu_op   = ALU_SLTU;
            end
            OP_ANDI: begin
                w_itype_ok = 1'b1;
                w_alu_op   = ALU_AND;
                w_ext_mode = EXT_ZERO;
            end
            OP_ORI: begin
                w_itype_ok = 1'b1;
                w_alu_op   = ALU_OR;
                w_ext_mode = EXT_ZERO;
            end
            OP_XORI: begin
                w_itype_ok = 1'b1;
                w_alu_op   = ALU_XOR;
                w_ext_mode = EXT_ZERO;
            end
            OP_LUI: begin
                w_itype_ok = 1'b1;
                w_alu_op   = ALU_LUI;
                w_ext_mode = EXT_LUI;
            end
            OP_LW: begin
                regWrite = 1'b1;
                aluSrc   = 1'b1;
                memRead  = 1'b1;
                memToReg = 2'b01;
            end
            OP_SW: begin
                aluSrc   = 1'b1;
                memWrite = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                branch   = 1'b1;
                w_alu_op = ALU_SUB;
            end
            OP_J: jump = 1'b1;
            OP_JAL: begin
                jump     = 1'b1;
                jumpj    = 1'b1;
                regWrite = 1'b1;
                regDst   = 2'b10;
                memToReg = 2'b10;
            end
            default: ;
        endcase
        if (w_rtype_ok) begin
            regWrite = 1'b1;
            regDst   = 2'b01;
        end
        if (w_itype_ok) begin
            regWrite = 1'b1;
            aluSrc   = 1'b1;
        end
    end

    assign aluControl = w_alu_op;
    assign w_imm_ext  = extend_imm(w_imm, w_ext_mode);
    assign w_alu_b    = aluSrc ? w_imm_ext : regData2;

    exec_alu u_alu (
        .i_a      (regData1),
        .i_b      (w_alu_b),
        .i_shamt  (w_shamt),
        .i_ctrl   (w_alu_op),
        .o_result (aluResult)
    );

    assign zero        = (aluResult == 32'd0);
    assign branchTaken = branch & (zero ^ (w_opcode == OP_BNE));

    // Byte address -> word index; upper bits drop out so the index wraps.
    assign w_idx = aluResult[AW+1:2];

    genvar gi;
    generate
        for (gi = 0; gi < DMEM_DEPTH; gi++) begin : g_word
            logic [31:0] r_word;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_word <= '0;
                end else if (memWrite && (w_idx == AW'(gi))) begin
                    r_word <= regData2;
                end
            end
            assign w_words[gi] = r_word;
        end
    endgenerate

    assign memData = memRead ? w_words[w_idx] : 32'd0;

`ifdef DMEM_DBG_EN
    assign dbgData = w_words[dbgAddr];
`endif

endmodule

// File: tb/tb_exec_mem_unit.sv
// Directed bench for exec_mem_unit: expectations are queued when each instruction is
// driven and drained against the DUT outputs once the combinational paths settle.
module tb_exec_mem_unit;

    localparam int DEPTH = 128;

    localparam int F_ALU  = 0;
    localparam int F_MEM  = 1;
    localparam int F_ZERO = 2;
    localparam int F_BT   = 3;
    localparam int F_CTRL = 4;
    localparam int F_AOP  = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instruction = '0;
    logic [31:0] regData1 = '0;
    logic [31:0] regData2 = '0;
    logic        regWrite, memRead, memWrite, aluSrc, branch, branchTaken;
    logic        jump, jumpr, jumpj, syscall, zero;
    logic [1:0]  regDst, memToReg;
    logic [4:0]  aluControl;
    logic [31:0] aluResult, memData;
`ifdef DMEM_DBG_EN
    logic [$clog2(DEPTH)-1:0] dbgAddr = '0;
    logic [31:0]              dbgData;
`endif

    typedef struct {
        string       tag;
        int          fld;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    exec_mem_unit #(.DMEM_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .regData1    (regData1),
        .regData2    (regData2),
        .regWrite    (regWrite),
        .regDst      (regDst),
        .memToReg    (memToReg),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .aluSrc      (aluSrc),
        .branch      (branch),
        .branchTaken (branchTaken),
        .jump        (jump),
        .jumpr       (jumpr),
        .jumpj       (jumpj),
        .syscall     (syscall),
        .aluControl  (aluControl),
        .aluResult   (aluResult),
        .zero        (zero),
        .memData     (memData)
`ifdef DMEM_DBG_EN
        ,
        .dbgAddr     (dbgAddr),
        .dbgData     (dbgData)
`endif
    );

    always #5 clk = ~clk;

    // {regWrite, regDst, memToReg, memRead, memWrite, aluSrc, branch, branchTaken, jump, jumpr, jumpj, syscall}
    function automatic logic [31:0] ctrl(input logic rw, input logic [1:0] rd, input logic [1:0] mtr,
                                         input logic mr, input logic mw, input logic as,
                                         input logic br, input logic bt, input logic j,
                                         input logic jr, input logic jj, input logic sc);
        return {18'd0, rw, rd, mtr, mr, mw, as, br, bt, j, jr, jj, sc};
    endfunction

    function automatic logic [31:0] observe(input int fld);
        case (fld)
            F_ALU:   return aluResult;
            F_MEM:   return memData;
            F_ZERO:  return {31'd0, zero};
            F_BT:    return {31'd0, branchTaken};
            F_CTRL:  return ctrl(regWrite, regDst, memToReg, memRead, memWrite, aluSrc,
                                 branch, branchTaken, jump, jumpr, jumpj, syscall);
            default: return {27'd0, aluControl};
        endcase
    endfunction

    function automatic logic [31:0] rtype(input logic [5:0] funct, input logic [4:0] shamt);
        return {6'h00, 5'd1, 5'd2, 5'd3, shamt, funct};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction

    task automatic issue(input string name, input logic [31:0] instr,
                         input logic [31:0] rs, input logic [31:0] rt);
        instruction = instr;
        regData1    = rs;
        regData2    = rt;
        $display("[%0t] %-8s instr=%h rs=%h rt=%h", $time, name, instr, rs, rt);
    endtask

    task automatic expect_val(input string tag, input int fld, input logic [31:0] e);
        exp_t item;
        item.tag = tag;
        item.fld = fld;
        item.exp = e;
        sb.push_back(item);
    endtask

    task automatic drain();
        exp_t        item;
        logic [31:0] obs;
        #1;
        while (sb.size() > 0) begin
            item = sb.pop_front();
            obs  = observe(item.fld);
            n_checks++;
            assert (obs === item.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", item.tag, obs, item.exp);
            end
        end
    endtask

    initial begin
        // Reset pulse with memory read of a never-written word
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue("lw", itype(6'h23, 16'h0040), 32'd0, 32'd0);
        expect_val("lw_reset_data", F_MEM, 32'h0);
        expect_val("lw_addr", F_ALU, 32'h40);
        expect_val("lw_ctrl", F_CTRL, ctrl(1, 2'b01 & 2'b00, 2'b01, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        drain();

        @(negedge clk);
        issue("sw", itype(6'h2B, 16'h01FC), 32'd0, 32'hDEADBEEF);
        expect_val("sw_ctrl", F_CTRL, ctrl(0, 2'b00, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        expect_val("sw_nomemread", F_MEM, 32'h0);
        drain();
        @(negedge clk);
        issue("lw", itype(6'h23, 16'h01FC), 32'd0, 32'd0);
        expect_val("lw_1fc", F_MEM, 32'hDEADBEEF);
        drain();
        @(negedge clk);
        issue("lw", itype(6'h23, 16'h01FC), 32'h200, 32'd0);
        expect_val("lw_3fc_addr", F_ALU, 32'h3FC);
        expect_val("lw_3fc_wrap", F_MEM, 32'hDEADBEEF);
        drain();
        @(negedge clk);
        issue("lw", itype(6'h23, 16'h01F8), 32'd0, 32'd0);
        expect_val("lw_1f8_untouched", F_MEM, 32'h0);
        drain();

        // Asynchronous clear between clock edges
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        issue("lw", itype(6'h23, 16'h01FC), 32'd0, 32'd0);
        expect_val("async_clear", F_MEM, 32'h0);
        drain();

        // A store presented during reset must not land
        @(negedge clk);
        reset = 1'b1;
        issue("sw", itype(6'h2B, 16'h0010), 32'd0, 32'h12345678);
        @(negedge clk);
        reset = 1'b0;
        issue("lw", itype(6'h23, 16'h0010), 32'd0, 32'd0);
        expect_val("write_blocked_in_reset", F_MEM, 32'h0);
        drain();

        @(negedge clk);
        issue("addi", itype(6'h08, 16'hFFFF), 32'd5, 32'd0);
        expect_val("addi_sext", F_ALU, 32'd4);
        expect_val("addi_ctrl", F_CTRL, ctrl(1, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        drain();
        @(negedge clk);
        issue("ori", itype(6'h0D, 16'hFFFF), 32'd5, 32'd0);
        expect_val("ori_zext", F_ALU, 32'h0000FFFF);
        expect_val("ori_aluctl", F_AOP, 32'd3);
        drain();
        @(negedge clk);
        issue("lui", itype(6'h0F, 16'h1234), 32'h5555, 32'd0);
        expect_val("lui", F_ALU, 32'h12340000);
        drain();

        @(negedge clk);
        issue("beq", itype(6'h04, 16'h0003), 32'd7, 32'd7);
        expect_val("beq_zero", F_ZERO, 32'd1);
        expect_val("beq_taken", F_BT, 32'd1);
        expect_val("beq_aluctl", F_AOP, 32'd1);
        drain();
        @(negedge clk);
        issue("bne", itype(6'h05, 16'h0003), 32'd7, 32'd7);
        expect_val("bne_eq_not_taken", F_BT, 32'd0);
        drain();
        @(negedge clk);
        issue("bne", itype(6'h05, 16'h0003), 32'd7, 32'd8);
        expect_val("bne_ne_taken", F_BT, 32'd1);
        expect_val("bne_ne_zero", F_ZERO, 32'd0);
        drain();

        @(negedge clk);
        issue("sra", rtype(6'h03, 5'd4), 32'd0, 32'h80000000);
        expect_val("sra", F_ALU, 32'hF8000000);
        expect_val("sra_ctrl", F_CTRL, ctrl(1, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        drain();
        @(negedge clk);
        issue("sltu", rtype(6'h2B, 5'd0), 32'd1, 32'hFFFFFFFF);
        expect_val("sltu", F_ALU, 32'd1);
        drain();
        @(negedge clk);
        issue("slt", rtype(6'h2A, 5'd0), 32'd1, 32'hFFFFFFFF);
        expect_val("slt", F_ALU, 32'd0);
        drain();
        @(negedge clk);
        issue("srlv", rtype(6'h06, 5'd9), 32'd4, 32'h000000F0);
        expect_val("srlv", F_ALU, 32'h0000000F);
        drain();
        @(negedge clk);
        issue("addu", rtype(6'h21, 5'd0), 32'hFFFFFFFF, 32'd2);
        expect_val("addu_wrap", F_ALU, 32'd1);
        drain();
        @(negedge clk);
        issue("nor", rtype(6'h27, 5'd0), 32'h0F0F0000, 32'h000000F0);
        expect_val("nor", F_ALU, 32'hF0F0FF0F);
        drain();

        @(negedge clk);
        issue("jal", {6'h03, 26'h0000100}, 32'd0, 32'd0);
        expect_val("jal_ctrl", F_CTRL, ctrl(1, 2'b10, 2'b10, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        drain();
        @(negedge clk);
        issue("jr", rtype(6'h08, 5'd0), 32'd0, 32'd0);
        expect_val("jr_ctrl", F_CTRL, ctrl(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        drain();
        @(negedge clk);
        issue("syscall", rtype(6'h0C, 5'd0), 32'd0, 32'd0);
        expect_val("syscall_ctrl", F_CTRL, ctrl(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        drain();
        @(negedge clk);
        issue("op3f", {6'h3F, 26'h3FFFFFF}, 32'd3, 32'd4);
        expect_val("unknown_op_ctrl", F_CTRL, 32'd0);
        expect_val("unknown_op_aluctl", F_AOP, 32'd0);
        drain();
        @(negedge clk);
        issue("fn3f", rtype(6'h3F, 5'd0), 32'd3, 32'd4);
        expect_val("unknown_fn_ctrl", F_CTRL, 32'd0);
        expect_val("unknown_fn_alu", F_ALU, 32'd7);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_mem_unit.md
EXEC_MEM_UNIT -- requirements
Module: exec_mem_unit

Interface
REQ-001 Parameter DMEM_DEPTH, default 128, data-memory depth in 32-bit words; power of two; address bits AW = log2(DMEM_DEPTH).
REQ-002 clk  in  1  single clock; all storage updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 instruction  in  32  current instruction word.
REQ-005 regData1  in  32  rs register value.
REQ-006 regData2  in  32  rt register value; also store data.
REQ-007 regWrite  out  1  register-file write enable.
REQ-008 regDst  out  2  destination select: 00 rt, 01 rd, 10 $31.
REQ-009 memToReg  out  2  writeback select: 00 ALU, 01 memory, 10 pc+4.
REQ-010 memRead / memWrite  out  1 each  data-memory read and write enables.
REQ-011 aluSrc  out  1  ALU operand B: 1 = extended immediate, 0 = regData2.
REQ-012 branch  out  1  beq or bne decoded.
REQ-013 branchTaken  out  1  branch AND (zero XOR bne).
REQ-014 jump / jumpr / jumpj  out  1 each  any jump / jr / jal.
REQ-015 syscall  out  1  syscall decoded.
REQ-016 aluControl  out  5  decoded ALU operation code.
REQ-017 aluResult  out  32  ALU result; also data-memory byte address.
REQ-018 zero  out  1  aluResult == 0.
REQ-019 memData  out  32  data-memory read data.

Function
REQ-020 Decode SHALL be purely combinational from instruction[31:26] and funct [5:0].
REQ-021 R-type (op 0x00): add/addu 20/21, sub/subu 22/23, and 24, or 25, xor 26, nor 27, slt 2A, sltu 2B, sll 00, srl 02, sra 03, sllv 04, srlv 06, srav 07 SHALL set regWrite=1 and regDst=01; jr 08 SHALL set jump=jumpr=1 and regWrite=0; syscall 0C SHALL set syscall=1 and all write enables to 0.
REQ-022 I-type with regDst=00, aluSrc=1, regWrite=1: addi 08, addiu 09, slti 0A, sltiu 0B, andi 0C, ori 0D, xori 0E, lui 0F.
REQ-023 Loads and stores: lw 23 SHALL set memRead=1 and memToReg=01; sw 2B SHALL set memWrite=1 and regWrite=0; both use ADD with a sign-extended immediate.
REQ-024 beq 04 and bne 05 SHALL set branch=1 and use SUB on regData1 - regData2; j 02 SHALL set jump=1; jal 03 SHALL set jump=jumpj=1, regWrite=1, regDst=10 and memToReg=10.
REQ-025 An unknown opcode or funct SHALL set all enables to 0 and aluControl to ADD.
REQ-026 Immediate extension: sign-extend for arithmetic, slt, load, store and branch; zero-extend for andi, ori and xori; lui operand SHALL be imm<<16.
REQ-027 ALU arithmetic SHALL wrap modulo 2^32 with no overflow trap; slt is signed, sltu unsigned; both return 0 or 1.
REQ-028 Shifts SHALL shift regData2 by instruction[10:6] (sll/srl/sra) or by regData1[4:0] (the v forms); sra and srav are arithmetic.
REQ-029 Memory word index SHALL be aluResult[AW+1:2]; bits [1:0] and the upper bits are ignored, so the index wraps modulo DMEM_DEPTH.
REQ-030 memData SHALL be the word at the index, combinationally, when memRead=1, otherwise 0.
REQ-031 A write SHALL occur on the rising clk edge when memWrite=1; a same-cycle read returns the old word.

Reset
REQ-032 reset SHALL clear every memory word to 0 asynchronously; writes are blocked while reset is high.
REQ-033 Decode and ALU outputs are combinational and SHALL not be affected by reset.

Configuration
REQ-034 With `DMEM_DBG_EN` defined, the ports dbgAddr (in, AW) and dbgData (out, 32) SHALL exist and give a combinational read of any memory word independent of memRead; without the macro, the ports and logic SHALL be absent.

Structure
REQ-035 Package exec_mem_pkg SHALL hold the opcode and funct constants and the aluControl encoding: ADD 0, SUB 1, AND 2, OR 3, XOR 4, NOR 5, SLT 6, SLTU 7, SLL 8, SRL 9, SRA 10, SLLV 11, SRLV 12, SRAV 13, LUI 14.
REQ-036 The ALU SHALL be one sub-module, exec_alu; decode and memory SHALL be inline.

Verification
REQ-037 Reset pulse, then lw from address 0x40 -> memData=0.
REQ-038 sw with rt=0xDEADBEEF and address 0x1FC, one clock, then lw at 0x1FC -> 0xDEADBEEF; lw at 0x3FC also returns it (wrap).
REQ-039 addi with rs=5 and imm=0xFFFF -> aluResult=4; ori with the same operands -> aluResult=0x0000FFFF.
REQ-040 beq with 7,7 -> zero=1, branchTaken=1; bne with 7,7 -> branchTaken=0.
REQ-041 sra with rt=0x80000000 and shamt=4 -> 0xF8000000; sltu 1 vs 0xFFFFFFFF -> 1; slt with the same operands -> 0.
REQ-042 jal -> regWrite=1, regDst=10, memToReg=10; syscall -> syscall=1, no write enables; opcode 0x3F -> all enables 0.
